// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage with a one-entry skid buffer and branch redirect.
// Optional misaligned-redirect trap enabled by defining IF_MISALIGN_TRAP_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instn_out,
    output logic [31:0] currpc,
    output logic [31:0] nextpc,
    output logic        instn_valid,
    output logic        misalign
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD, TRAP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instn_q, instn_d;
    logic [31:0] currpc_q, currpc_d;
    logic [31:0] nextpc_q, nextpc_d;
    logic [31:0] skid_word_q, skid_word_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;
    logic        xfer, consume, bad_target;
    logic [31:0] target;

`ifdef IF_MISALIGN_TRAP_EN
    assign target     = redirect_pc;
    assign bad_target = |redirect_pc[1:0];
`else
    assign target     = redirect_pc & ~32'h3;
    assign bad_target = 1'b0;
`endif

    assign imem_req    = state_q == REQ;
    assign imem_addr   = pc_q;
    assign instn_out   = instn_q;
    assign currpc      = currpc_q;
    assign nextpc      = nextpc_q;
    assign instn_valid = valid_q;
    assign misalign    = misalign_q;
    assign xfer        = imem_req && imem_ready;
    assign consume     = valid_q && !stall;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instn_d     = instn_q;
        currpc_d    = currpc_q;
        nextpc_d    = nextpc_q;
        valid_d     = valid_q;
        skid_word_d = skid_word_q;
        skid_pc_d   = skid_pc_q;
        misalign_d  = misalign_q;
        if (state_q != TRAP && redirect) begin
            valid_d     = 1'b0;
            skid_word_d = '0;
            skid_pc_d   = '0;
            state_d     = bad_target ? TRAP : REQ;
            misalign_d  = misalign_q || bad_target;
            pc_d        = bad_target ? pc_q : target;
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    pc_d = xfer ? pc_q + 32'd4 : pc_q;
                    if (xfer && (!valid_q || consume)) begin
                        instn_d  = imem_rdata;
                        currpc_d = pc_q;
                        nextpc_d = pc_q + 32'd4;
                        valid_d  = 1'b1;
                    end else if (xfer) begin
                        // slot full and stalled: park the word instead of refetching it
                        skid_word_d = imem_rdata;
                        skid_pc_d   = pc_q;
                        state_d     = HOLD;
                    end else if (consume) begin
                        valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (consume) begin
                        instn_d  = skid_word_q;
                        currpc_d = skid_pc_q;
                        nextpc_d = skid_pc_q + 32'd4;
                        state_d  = REQ;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            instn_q     <= '0;
            currpc_q    <= '0;
            nextpc_q    <= '0;
            valid_q     <= 1'b0;
            skid_word_q <= '0;
            skid_pc_q   <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instn_q     <= instn_d;
            currpc_q    <= currpc_d;
            nextpc_q    <= nextpc_d;
            valid_q     <= valid_d;
            skid_word_q <= skid_word_d;
            skid_pc_q   <= skid_pc_d;
            misalign_q  <= misalign_d;
        end
    end
endmodule
